// File: rtl/uart_cmd_pkg.sv
// Shared constants and types for the UART command bridge.
//   OP_*   : host opcode bytes
//   RSP_*  : status bytes returned to the host
//   state_t: bridge FSM states
package uart_cmd_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned WORD_W = 32;

  localparam logic [BYTE_W-1:0] OP_W  = 8'h57;
  localparam logic [BYTE_W-1:0] OP_L  = 8'h4C;
  localparam logic [BYTE_W-1:0] OP_R  = 8'h52;
  localparam logic [BYTE_W-1:0] OP_X  = 8'h58;
  localparam logic [BYTE_W-1:0] RSP_K = 8'h4B;
  localparam logic [BYTE_W-1:0] RSP_E = 8'h45;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ADDR    = 3'd1,
    DATA    = 3'd2,
    EXEC    = 3'd3,
    RD_WAIT = 3'd4,
    RESP    = 3'd5,
    RD_RESP = 3'd6
  } state_t;

  // Opcodes followed by a 4-byte address field.
  function automatic logic has_addr(input logic [BYTE_W-1:0] op);
    return (op == OP_W) || (op == OP_L) || (op == OP_R);
  endfunction

endpackage

// File: rtl/uart_cmd_shift32.sv
// 32-bit byte-shift register with a 2-bit byte counter.
//   clr       : clear value and counter
//   shift     : shift din into the low byte
//   q         : current value
//   shifted_c : value q would take on this shift (combinational)
//   last_c    : this shift completes the 4th byte (combinational)
module uart_cmd_shift32
  import uart_cmd_pkg::*;
(
  input  logic              clk,
  input  logic              c_ex_rst,
  input  logic              clr,
  input  logic              shift,
  input  logic [BYTE_W-1:0] din,
  output logic [WORD_W-1:0] q,
  output logic [WORD_W-1:0] shifted_c,
  output logic              last_c
);

  logic [1:0] cnt;

  assign shifted_c = {q[WORD_W-BYTE_W-1:0], din};
  assign last_c    = shift && (cnt == 2'd3);

  always_ff @(posedge clk) begin
    if (c_ex_rst) begin
      q   <= '0;
      cnt <= '0;
    end else if (clr) begin
      q   <= '0;
      cnt <= '0;
    end else if (shift) begin
      q   <= shifted_c;
      cnt <= cnt + 2'd1;
    end
  end

endmodule

// File: rtl/uart_cmd_bridge.sv
// UART host command decoder: turns byte frames into single-beat ic0/ic1
// accesses and a user-reset request, and returns status/read data bytes.
//   rx_valid/rx_data          : received bytes from the UART receiver
//   tx_valid/tx_data/tx_ready : bytes to the UART transmitter
//   ic0_*_wr_*, ic0_*_rd_*    : ic0 single-beat write / read master
//   ic0_*_slv_rd_*_3          : ic0 read return
//   ic1_*_wr_*                : ic1 (instruction memory) write master
//   c_user_rst                : one-cycle SoC user-reset request
module uart_cmd_bridge
  import uart_cmd_pkg::*;
#(
  parameter int unsigned FRAME_TIMEOUT = 1000000,
  parameter int unsigned RD_TIMEOUT    = 255
) (
  input  logic              clk,
  input  logic              c_ex_rst,
  input  logic              rx_valid,
  input  logic [BYTE_W-1:0] rx_data,
  input  logic              tx_ready,
  output logic              tx_valid,
  output logic [BYTE_W-1:0] tx_data,
  output logic              ic0_c_axi_mst_wr_valid,
  output logic [WORD_W-1:0] ic0_axi_mst_wr_addr,
  output logic [WORD_W-1:0] ic0_axi_mst_wr_data,
  output logic              ic0_c_axi_mst_rd_valid,
  output logic [WORD_W-1:0] ic0_axi_mst_rd_addr,
  input  logic              ic0_c_axi_slv_rd_ready_3,
  input  logic [WORD_W-1:0] ic0_axi_slv_rd_data_3,
  output logic              ic1_c_axi_mst_wr_valid,
  output logic [WORD_W-1:0] ic1_axi_mst_wr_addr,
  output logic [WORD_W-1:0] ic1_axi_mst_wr_data,
  output logic              c_user_rst
);

  localparam int unsigned CNT_W = 32;

  state_t            state_q, state_n;
  logic [BYTE_W-1:0] op_q, op_n;
  logic [CNT_W-1:0]  cnt_q, cnt_n;
  logic [WORD_W-1:0] rd_q, rd_n;

  logic              tx_valid_n;
  logic [BYTE_W-1:0] tx_data_n;
  logic              ic0_wr_valid_n, ic1_wr_valid_n, ic0_rd_valid_n, user_rst_n;
  logic [WORD_W-1:0] ic0_wr_addr_n, ic0_wr_data_n, ic0_rd_addr_n;
  logic [WORD_W-1:0] ic1_wr_addr_n, ic1_wr_data_n;

  logic              sh_clr, addr_shift, data_shift;
  logic [WORD_W-1:0] addr_q, addr_shifted_c, data_q, data_shifted_c;
  logic              addr_last_c, data_last_c;

  uart_cmd_shift32 u_addr (
    .clk       (clk),
    .c_ex_rst  (c_ex_rst),
    .clr       (sh_clr),
    .shift     (addr_shift),
    .din       (rx_data),
    .q         (addr_q),
    .shifted_c (addr_shifted_c),
    .last_c    (addr_last_c)
  );

  uart_cmd_shift32 u_data (
    .clk       (clk),
    .c_ex_rst  (c_ex_rst),
    .clr       (sh_clr),
    .shift     (data_shift),
    .din       (rx_data),
    .q         (data_q),
    .shifted_c (data_shifted_c),
    .last_c    (data_last_c)
  );

  // Next-state and registered-output logic. Strobes are computed on the
  // transition into EXEC so the registered strobe is high during EXEC.
  always_comb begin
    state_n        = state_q;
    op_n           = op_q;
    cnt_n          = cnt_q;
    rd_n           = rd_q;
    tx_valid_n     = tx_valid;
    tx_data_n      = tx_data;
    ic0_wr_valid_n = 1'b0;
    ic1_wr_valid_n = 1'b0;
    ic0_rd_valid_n = 1'b0;
    user_rst_n     = 1'b0;
    ic0_wr_addr_n  = ic0_axi_mst_wr_addr;
    ic0_wr_data_n  = ic0_axi_mst_wr_data;
    ic0_rd_addr_n  = ic0_axi_mst_rd_addr;
    ic1_wr_addr_n  = ic1_axi_mst_wr_addr;
    ic1_wr_data_n  = ic1_axi_mst_wr_data;
    sh_clr         = 1'b0;
    addr_shift     = 1'b0;
    data_shift     = 1'b0;

    case (state_q)
      IDLE: begin
        if (rx_valid) begin
          op_n  = rx_data;
          cnt_n = '0;
          if (has_addr(rx_data)) begin
            state_n = ADDR;
            sh_clr  = 1'b1;
          end else if (rx_data == OP_X) begin
            state_n    = EXEC;
            user_rst_n = 1'b1;
          end else begin
            state_n    = RESP;
            tx_valid_n = 1'b1;
            tx_data_n  = RSP_E;
          end
        end
      end

      ADDR: begin
        if (rx_valid) begin
          addr_shift = 1'b1;
          cnt_n      = '0;
          if (addr_last_c) begin
            if (op_q == OP_R) begin
              state_n        = EXEC;
              ic0_rd_valid_n = 1'b1;
              ic0_rd_addr_n  = addr_shifted_c;
            end else begin
              state_n = DATA;
            end
          end
        end else begin
          cnt_n = cnt_q + CNT_W'(1);
          if (cnt_n == CNT_W'(FRAME_TIMEOUT)) begin
            state_n = IDLE;
            cnt_n   = '0;
          end
        end
      end

      DATA: begin
        if (rx_valid) begin
          data_shift = 1'b1;
          cnt_n      = '0;
          if (data_last_c) begin
            state_n = EXEC;
            if (op_q == OP_W) begin
              ic0_wr_valid_n = 1'b1;
              ic0_wr_addr_n  = addr_q;
              ic0_wr_data_n  = data_shifted_c;
            end else begin
              ic1_wr_valid_n = 1'b1;
              ic1_wr_addr_n  = addr_q;
              ic1_wr_data_n  = data_shifted_c;
            end
          end
        end else begin
          cnt_n = cnt_q + CNT_W'(1);
          if (cnt_n == CNT_W'(FRAME_TIMEOUT)) begin
            state_n = IDLE;
            cnt_n   = '0;
          end
        end
      end

      EXEC: begin
        cnt_n = '0;
        if (op_q == OP_R) begin
          state_n = RD_WAIT;
        end else begin
          state_n    = RESP;
          tx_valid_n = 1'b1;
          tx_data_n  = RSP_K;
        end
      end

      // Ready wins over a coincident timeout.
      RD_WAIT: begin
        cnt_n = cnt_q + CNT_W'(1);
        if (ic0_c_axi_slv_rd_ready_3) begin
          state_n    = RD_RESP;
          cnt_n      = '0;
          tx_valid_n = 1'b1;
          tx_data_n  = ic0_axi_slv_rd_data_3[WORD_W-1 -: BYTE_W];
          rd_n       = {ic0_axi_slv_rd_data_3[WORD_W-BYTE_W-1:0], BYTE_W'(0)};
        end else if (cnt_n == CNT_W'(RD_TIMEOUT)) begin
          state_n    = RESP;
          cnt_n      = '0;
          tx_valid_n = 1'b1;
          tx_data_n  = RSP_E;
        end
      end

      RESP: begin
        if (tx_valid && tx_ready) begin
          state_n    = IDLE;
          tx_valid_n = 1'b0;
          tx_data_n  = '0;
        end
      end

      // rd_q holds the bytes still to send, next one in the top byte.
      RD_RESP: begin
        if (tx_valid && tx_ready) begin
          if (cnt_q == CNT_W'(3)) begin
            state_n    = IDLE;
            cnt_n      = '0;
            tx_valid_n = 1'b0;
            tx_data_n  = '0;
          end else begin
            cnt_n     = cnt_q + CNT_W'(1);
            tx_data_n = rd_q[WORD_W-1 -: BYTE_W];
            rd_n      = {rd_q[WORD_W-BYTE_W-1:0], BYTE_W'(0)};
          end
        end
      end

      default: state_n = IDLE;
    endcase
  end

  // State, datapath and output registers.
  always_ff @(posedge clk) begin
    if (c_ex_rst) begin
      state_q                <= IDLE;
      op_q                   <= '0;
      cnt_q                  <= '0;
      rd_q                   <= '0;
      tx_valid               <= 1'b0;
      tx_data                <= '0;
      ic0_c_axi_mst_wr_valid <= 1'b0;
      ic0_axi_mst_wr_addr    <= '0;
      ic0_axi_mst_wr_data    <= '0;
      ic0_c_axi_mst_rd_valid <= 1'b0;
      ic0_axi_mst_rd_addr    <= '0;
      ic1_c_axi_mst_wr_valid <= 1'b0;
      ic1_axi_mst_wr_addr    <= '0;
      ic1_axi_mst_wr_data    <= '0;
      c_user_rst             <= 1'b0;
    end else begin
      state_q                <= state_n;
      op_q                   <= op_n;
      cnt_q                  <= cnt_n;
      rd_q                   <= rd_n;
      tx_valid               <= tx_valid_n;
      tx_data                <= tx_data_n;
      ic0_c_axi_mst_wr_valid <= ic0_wr_valid_n;
      ic0_axi_mst_wr_addr    <= ic0_wr_addr_n;
      ic0_axi_mst_wr_data    <= ic0_wr_data_n;
      ic0_c_axi_mst_rd_valid <= ic0_rd_valid_n;
      ic0_axi_mst_rd_addr    <= ic0_rd_addr_n;
      ic1_c_axi_mst_wr_valid <= ic1_wr_valid_n;
      ic1_axi_mst_wr_addr    <= ic1_wr_addr_n;
      ic1_axi_mst_wr_data    <= ic1_wr_data_n;
      c_user_rst             <= user_rst_n;
    end
  end

endmodule
